netlist_equiv_checker: RTL

- Streaming equivalence checker for the netlist optimisation flow.
- Each cycle it can accept one result-vector pair: the original netlist's outputs and the instruction-reduced netlist's outputs for the same stimulus.
- It compares the two, counts mismatches, captures the first failure and compacts the optimised results into a MISR signature.
- It replaces one-shot readmemb/writememb result dumps with a parametrised, multi-vector, cycle-accurate checker placed between the stimulus player and the report logic.

---
 rtl/netlist_equiv_checker.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/netlist_equiv_checker.sv
// Streaming equivalence checker: compares original vs. optimised netlist results,
// counts mismatches, captures the first failure and compacts res_b into a MISR signature.
module netlist_equiv_checker #(
  parameter int              OUT_W = 80,
  parameter int              SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
  parameter int              CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld_in,
  output logic             ready_out,
  input  logic [OUT_W-1:0] res_a,
  input  logic [OUT_W-1:0] res_b,
  input  logic             last_in,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [OUT_W-1:0] first_fail_diff,
  output logic [SIG_W-1:0] sig
);

  localparam int               NCH     = (OUT_W + SIG_W - 1) / SIG_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             drain_cnt_q, drain_cnt_d;

  logic             s1_vld_q, s1_vld_d;
  logic [OUT_W-1:0] s1_a_q, s1_a_d;
  logic [OUT_W-1:0] s1_b_q, s1_b_d;
  logic             s1_last_q, s1_last_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;

  logic             s2_vld_q, s2_vld_d;
  logic [OUT_W-1:0] s2_diff_q, s2_diff_d;
  logic [SIG_W-1:0] s2_fold_q, s2_fold_d;
  logic             s2_last_q, s2_last_d;
  logic [CNT_W-1:0] s2_idx_q, s2_idx_d;

  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [OUT_W-1:0] ff_diff_q, ff_diff_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             accept;
  logic [NCH*SIG_W-1:0] b_pad;
  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] sig_step;

  assign ready_out = (state_q == ST_RUN) && !start;
  assign accept    = vld_in && ready_out;

  // Fold res_b into SIG_W-bit chunks from bit 0; the top chunk is zero-padded.
  always_comb begin
    b_pad = '0;
    b_pad[OUT_W-1:0] = s1_b_q;
    fold = '0;
    for (int i = 0; i < NCH; i++) begin
      fold = fold ^ b_pad[i*SIG_W +: SIG_W];
    end
  end

  assign sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ s2_fold_q;

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    s1_vld_d       = 1'b0;
    s1_a_d         = s1_a_q;
    s1_b_d         = s1_b_q;
    s1_last_d      = s1_last_q;
    s1_idx_d       = s1_idx_q;
    s2_vld_d       = 1'b0;
    s2_diff_d      = s2_diff_q;
    s2_fold_d      = s2_fold_q;
    s2_last_d      = s2_last_q;
    s2_idx_d       = s2_idx_q;
    vec_cnt_d      = vec_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    ff_idx_d       = ff_idx_q;
    ff_diff_d      = ff_diff_q;
    sig_d          = sig_q;
    done_d         = done_q;
    pass_d         = pass_q;

    if (start) begin
      // Restart from any state; in-flight pairs are discarded.
      state_d        = ST_RUN;
      drain_cnt_d    = 1'b0;
      s1_last_d      = 1'b0;
      s2_last_d      = 1'b0;
      vec_cnt_d      = '0;
      mismatch_cnt_d = '0;
      ff_idx_d       = '0;
      ff_diff_d      = '0;
      sig_d          = '0;
      done_d         = 1'b0;
      pass_d         = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept && last_in) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_cnt_d = 1'b1;
          if (drain_cnt_q) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase

      // Stage 1: capture the pair and its index (saturated vec_cnt).
      if (accept) begin
        s1_vld_d  = 1'b1;
        s1_a_d    = res_a;
        s1_b_d    = res_b;
        s1_last_d = last_in;
        s1_idx_d  = vec_cnt_q;
        if (vec_cnt_q != CNT_MAX) begin
          vec_cnt_d = vec_cnt_q + CNT_ONE;
        end
      end

      if (s1_vld_q) begin
        s2_vld_d  = 1'b1;
        s2_diff_d = s1_a_q ^ s1_b_q;
        s2_fold_d = fold;
        s2_last_d = s1_last_q;
        s2_idx_d  = s1_idx_q;
      end

      // Stage 2: result update. mismatch_cnt never wraps, so zero means no failure yet.
      if (s2_vld_q) begin
        sig_d = sig_step;
        if (s2_diff_q != '0) begin
          if (mismatch_cnt_q == '0) begin
            ff_idx_d  = s2_idx_q;
            ff_diff_d = s2_diff_q;
          end
          if (mismatch_cnt_q != CNT_MAX) begin
            mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
          end
        end
        if (s2_last_q) begin
          done_d = 1'b1;
          pass_d = (mismatch_cnt_d == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      drain_cnt_q    <= 1'b0;
      s1_vld_q       <= 1'b0;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      s1_last_q      <= 1'b0;
      s1_idx_q       <= '0;
      s2_vld_q       <= 1'b0;
      s2_diff_q      <= '0;
      s2_fold_q      <= '0;
      s2_last_q      <= 1'b0;
      s2_idx_q       <= '0;
      vec_cnt_q      <= '0;
      mismatch_cnt_q <= '0;
      ff_idx_q       <= '0;
      ff_diff_q      <= '0;
      sig_q          <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      s1_vld_q       <= s1_vld_d;
      s1_a_q         <= s1_a_d;
      s1_b_q         <= s1_b_d;
      s1_last_q      <= s1_last_d;
      s1_idx_q       <= s1_idx_d;
      s2_vld_q       <= s2_vld_d;
      s2_diff_q      <= s2_diff_d;
      s2_fold_q      <= s2_fold_d;
      s2_last_q      <= s2_last_d;
      s2_idx_q       <= s2_idx_d;
      vec_cnt_q      <= vec_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      ff_idx_q       <= ff_idx_d;
      ff_diff_q      <= ff_diff_d;
      sig_q          <= sig_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
    end
  end

  assign done            = done_q;
  assign pass            = pass_q;
  assign vec_cnt         = vec_cnt_q;
  assign mismatch_cnt    = mismatch_cnt_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_diff = ff_diff_q;
  assign sig             = sig_q;

endmodule
